// File: rtl/rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wr_arbiter
//
// Two-requester write arbiter in front of a single register-file write port.
// Requester 0 is the ALU writeback path, requester 1 the multi-cycle mul/div
// unit. At most one write is accepted per cycle. Contention is resolved
// round-robin against last_gnt. The accepted write appears on the registered
// wr_* outputs one cycle later. Writes to register 0 are accepted but leave
// wr_en low.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   valid0/addr0/data0    requester 0 write request (held until accepted)
//   ready0                requester 0 accepted this cycle (combinational)
//   valid1/addr1/data1    requester 1 write request (held until accepted)
//   ready1                requester 1 accepted this cycle (combinational)
//   stall                 register-file port busy; nothing is accepted
//   wr_en/wr_addr/wr_data registered register-file write port
//   sel                   registered port index of the last accepted write
//   last_gnt              round-robin pointer: port granted most recently
// -----------------------------------------------------------------------------
module rf_wr_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid0,
  input  logic [4:0]  addr0,
  input  logic [31:0] data0,
  output logic        ready0,
  input  logic        valid1,
  input  logic [4:0]  addr1,
  input  logic [31:0] data1,
  output logic        ready1,
  input  logic        stall,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        sel,
  output logic        last_gnt
);

  logic        xfer;
  logic [4:0]  xfer_addr;
  logic [31:0] xfer_data;

  // Grant decision. The grant depends only on the valids, stall, rst and the
  // round-robin pointer, so address and data never feed back into the ready
  // paths. Under contention the port that did not win last time goes first.
  // The two readies are therefore mutually exclusive by construction.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (!rst && !stall) begin
      if (valid0 && valid1) begin
        ready0 = last_gnt;
        ready1 = ~last_gnt;
      end else begin
        ready0 = valid0;
        ready1 = valid1;
      end
    end
  end

  // Select the winning requester's address and data for the output register.
  // When there is no transfer, the mux value is ignored.
  always_comb begin
    xfer      = ready0 | ready1;
    xfer_addr = ready1 ? addr1 : addr0;
    xfer_data = ready1 ? data1 : data0;
  end

  // Output register and round-robin pointer.
  // Reset leaves last_gnt at 1 so that port 0 wins the first contention.
  // A write to register 0 still updates addr/data/sel/last_gnt, but wr_en
  // stays low, so the register file discards it.
  // Idle and stalled cycles only drop wr_en. All other state is held, which
  // is also what freezes arbitration order across a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= 5'd0;
      wr_data  <= 32'd0;
      sel      <= 1'b0;
      last_gnt <= 1'b1;
    end else if (xfer) begin
      wr_en    <= (xfer_addr != 5'd0);
      wr_addr  <= xfer_addr;
      wr_data  <= xfer_data;
      sel      <= ready1;
      last_gnt <= ready1;
    end else begin
      wr_en    <= 1'b0;
    end
  end

endmodule
